request_feeder: RTL and testbench
=================================

REQUEST_FEEDER -- requirements
Module: request_feeder

Interface
REQ-001 Parameter: TIME_WIDTH, 64, width of CPU-cycle timestamps and time counter.
REQ-002 Parameter: STALL_WIDTH, 16, width of stall counter.
REQ-003 Port: CPU_clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  input  1  upstream trace parser offers a request.
REQ-006 Port: req_time  input  TIME_WIDTH  CPU cycle at which the request arrives.
REQ-007 Port: req_opcode  input  parsed_op_t  request opcode.
REQ-008 Port: req_address  input  ADDRESS_WIDTH  request address.
REQ-009 Port: req_ready  output  1  feeder accepts the offered request this cycle.
REQ-010 Port: trace_end  input  1  level; upstream has no further requests.
REQ-011 Port: queue_full  input  1  downstream request queue cannot accept.
REQ-012 Port: queue_empty  input  1  downstream request queue holds no valid entries.
REQ-013 Port: op_ready_s  output  1  one-cycle strobe; new operation presented to queue.
REQ-014 Port: opcode_out  output  parsed_op_t  opcode of held request.
REQ-015 Port: address_out  output  ADDRESS_WIDTH  address of held request.
REQ-016 Port: cur_time  output  TIME_WIDTH  current simulated CPU cycle.
REQ-017 Port: stall_cnt  output  STALL_WIDTH  cycles an issue was blocked by queue_full.
REQ-018 Port: order_err  output  1  sticky; a request arrived with time earlier than its predecessor.
REQ-019 Port: all_done  output  1  trace finished and queue drained.

Function
REQ-020 State machine SHALL have states EMPTY (no held request), HOLD (one request held), DONE.
REQ-021 Accept = req_valid && req_ready; req_ready SHALL be 1 in EMPTY, 1 in HOLD only in a cycle where op_ready_s=1, 0 in DONE.
REQ-022 On accept, req_time/req_opcode/req_address SHALL be registered into the hold register and state SHALL be HOLD next cycle.
REQ-023 Due = (state==HOLD) && (hold_time <= cur_time), unsigned compare.
REQ-024 op_ready_s SHALL equal Due && !queue_full, combinational from registered state and queue_full; no added latency.
REQ-025 opcode_out/address_out SHALL reflect the hold register whenever state==HOLD; the queue samples them with op_ready_s on the same edge.
REQ-026 Issue without a simultaneous accept: HOLD -> EMPTY; issue with a simultaneous accept: stay HOLD with new request (back-to-back, one request per cycle).
REQ-027 Requests SHALL issue strictly in acceptance order; late requests (hold_time < cur_time) issue as soon as not blocked.
REQ-028 cur_time SHALL increment by 1 every cycle in EMPTY and HOLD, hold its value in DONE, and saturate at all-ones.
REQ-029 Skip-ahead: in HOLD with queue_empty=1 and hold_time > cur_time+1, cur_time SHALL load hold_time next cycle instead of incrementing.
REQ-030 stall_cnt SHALL increment each cycle Due && queue_full, saturating at all-ones.
REQ-031 order_err SHALL set on accept when req_time < the previously accepted request's time, remain set until reset, and the request SHALL still be accepted and issued normally.
REQ-032 EMPTY -> DONE when trace_end=1 and req_valid=0; trace_end SHALL be ignored in HOLD until the held request issues.
REQ-033 DONE is terminal until reset; all_done = (state==DONE) && queue_empty.
REQ-034 req_valid while trace_end=1 in EMPTY SHALL be accepted (request wins over end).

Reset
REQ-035 rst_n low SHALL immediately force state EMPTY, hold register invalid, cur_time=0, stall_cnt=0, order_err=0, previous-time register=0.
REQ-036 During reset outputs SHALL be: op_ready_s=0, req_ready=0, all_done=0, opcode_out/address_out=0.
REQ-037 Reset asserted mid-HOLD SHALL discard the held request with no strobe emitted.
REQ-038 After rst_n deassertion the first clock edge SHALL have req_ready=1 (EMPTY).

Verification
REQ-039 Queue empty, request time=10 accepted at cur_time=2 -> cur_time jumps to 10 next cycle, op_ready_s=1 that cycle with matching opcode/address.
REQ-040 queue_empty=0, queue_full=0, requests times 5,5,6 offered continuously from cur_time=5 -> three consecutive strobes, one per cycle, in order.
REQ-041 Held request due, queue_full=1 for 7 cycles -> no strobe, req_ready=0, stall_cnt=7, strobe on first cycle queue_full=0.
REQ-042 Request time=20 then time=15 -> order_err=1 after second accept, both issued in acceptance order.
REQ-043 trace_end=1 with last request held -> DONE only after its strobe; all_done=1 once queue_empty=1; cur_time frozen.
REQ-044 rst_n pulsed low while HOLD with due request and queue_full=1 -> no strobe, all counters 0, EMPTY after release.

Source files
------------

// File: rtl/request_feeder.sv
// request_feeder: holds one trace request at a time and releases it to the
// downstream request queue once the simulated CPU time reaches its
// timestamp. It also keeps the simulated CPU clock, with a skip-ahead when
// the machine is idle, plus stall and ordering diagnostics.
//
// Handshakes:
//   - Upstream valid/ready: a request moves when req_valid && req_ready on a
//     rising edge. req_ready never depends on req_valid.
//   - Downstream strobe: op_ready_s is a one-cycle strobe. The queue captures
//     opcode_out/address_out on the same edge. The strobe is held off while
//     queue_full is high.

package request_feeder_pkg;
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_FETCH = 2'd3
  } parsed_op_t;
endpackage

module request_feeder
  import request_feeder_pkg::*;
#(
  parameter int TIME_WIDTH    = 64,
  parameter int STALL_WIDTH   = 16,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     CPU_clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [TIME_WIDTH-1:0]    req_time,
  input  parsed_op_t               req_opcode,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  output logic                     req_ready,
  input  logic                     trace_end,
  input  logic                     queue_full,
  input  logic                     queue_empty,
  output logic                     op_ready_s,
  output parsed_op_t               opcode_out,
  output logic [ADDRESS_WIDTH-1:0] address_out,
  output logic [TIME_WIDTH-1:0]    cur_time,
  output logic [STALL_WIDTH-1:0]   stall_cnt,
  output logic                     order_err,
  output logic                     all_done,
  output logic [1:0]               fsm_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [TIME_WIDTH-1:0]  TIME_ONE  = 1;
  localparam logic [TIME_WIDTH:0]    TIME_ONEX = 1;
  localparam logic [STALL_WIDTH-1:0] STALL_ONE = 1;

  state_t                   state;
  state_t                   state_next;
  logic [TIME_WIDTH-1:0]    hold_time;
  parsed_op_t               hold_op;
  logic [ADDRESS_WIDTH-1:0] hold_addr;
  logic [TIME_WIDTH-1:0]    prev_time;
  logic                     due;
  logic                     accept;
  logic                     skip_ahead;
  logic [TIME_WIDTH:0]      cur_time_plus1;

  assign fsm_state = state;

  // Held request is due once the simulated clock has reached its timestamp.
  assign due = (state == S_HOLD) && (hold_time <= cur_time);

  // One extra bit so the comparison cannot wrap at the top of the time range.
  assign cur_time_plus1 = {1'b0, cur_time} + TIME_ONEX;
  assign skip_ahead = (state == S_HOLD) && queue_empty &&
                      ({1'b0, hold_time} > cur_time_plus1);

  // State register.
  always_ff @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_next;
  end

  // Next state and handshake outputs; rst_n gates req_ready so nothing is
  // offered while reset is held.
  always_comb begin
    state_next  = state;
    op_ready_s  = 1'b0;
    req_ready   = 1'b0;
    opcode_out  = OP_NONE;
    address_out = '0;
    all_done    = 1'b0;
    accept      = 1'b0;
    case (state)
      S_EMPTY: begin
        req_ready = rst_n;
        accept    = req_valid && req_ready;
        if (accept)         state_next = S_HOLD;
        else if (trace_end) state_next = S_DONE;
      end
      S_HOLD: begin
        opcode_out  = hold_op;
        address_out = hold_addr;
        op_ready_s  = due && !queue_full;
        req_ready   = rst_n && op_ready_s;
        accept      = req_valid && req_ready;
        if (op_ready_s && !accept) state_next = S_EMPTY;
      end
      S_DONE: begin
        all_done = queue_empty;
      end
      default: state_next = S_EMPTY;
    endcase
  end

  // Hold register and ordering check, loaded on every accept.
  always_ff @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_time <= '0;
      hold_op   <= OP_NONE;
      hold_addr <= '0;
      prev_time <= '0;
      order_err <= 1'b0;
    end else if (accept) begin
      hold_time <= req_time;
      hold_op   <= req_opcode;
      hold_addr <= req_address;
      prev_time <= req_time;
      if (req_time < prev_time) order_err <= 1'b1;
    end
  end

  // Simulated CPU clock: jumps to an idle-wait target, otherwise counts up and
  // saturates; frozen once the trace is done.
  always_ff @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_time <= '0;
    end else if (state != S_DONE) begin
      if (skip_ahead)          cur_time <= hold_time;
      else if (cur_time != '1) cur_time <= cur_time + TIME_ONE;
    end
  end

  // Cycles in which a due request was blocked by a full queue.
  always_ff @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n)                              stall_cnt <= '0;
    else if (due && queue_full && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_ONE;
  end

endmodule

// File: tb/tb_request_feeder.sv
// Bench for request_feeder: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based behavioural model of the feeder.
module tb_request_feeder;
  import request_feeder_pkg::*;

  // Clock and reset.
  logic CPU_clk = 1'b0;
  always #5 CPU_clk = ~CPU_clk;
  logic rst_n = 1'b0;

  logic        req_valid = 1'b0;
  logic [63:0] req_time = '0;
  parsed_op_t  req_opcode = OP_NONE;
  logic [31:0] req_address = '0;
  logic        req_ready;
  logic        trace_end = 1'b0;
  logic        queue_full = 1'b0;
  logic        queue_empty = 1'b0;
  logic        op_ready_s;
  parsed_op_t  opcode_out;
  logic [31:0] address_out;
  logic [63:0] cur_time;
  logic [15:0] stall_cnt;
  logic        order_err;
  logic        all_done;
  logic [1:0]  fsm_state;

  request_feeder dut (
    .CPU_clk(CPU_clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_time(req_time), .req_opcode(req_opcode),
    .req_address(req_address), .req_ready(req_ready), .trace_end(trace_end),
    .queue_full(queue_full), .queue_empty(queue_empty), .op_ready_s(op_ready_s),
    .opcode_out(opcode_out), .address_out(address_out), .cur_time(cur_time),
    .stall_cnt(stall_cnt), .order_err(order_err), .all_done(all_done),
    .fsm_state(fsm_state)
  );

  // Reference model: pending requests in a queue, plain counters for time.
  typedef struct {
    logic [63:0] t;
    parsed_op_t  op;
    logic [31:0] a;
  } req_t;

  req_t        held[$];
  logic [33:0] exp_q[$];  // {opcode, address} in acceptance order
  bit          done;
  logic [63:0] m_time;
  logic [15:0] m_stall;
  bit          m_err;
  logic [63:0] m_prev;
  int          dut_strobes;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    held.delete();
    exp_q.delete();
    done = 0;
    m_time = '0;
    m_stall = '0;
    m_err = 0;
    m_prev = '0;
    dut_strobes = 0;
  endtask

  // Asynchronous reset pulse, entered at posedge+1; leaves at negedge+1.
  task automatic do_reset();
    req_valid = 1'b0;
    trace_end = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_op_ready_s", op_ready_s, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_all_done", all_done, 0);
    check("rst_opcode", opcode_out, 0);
    check("rst_address", address_out, 0);
    check("rst_cur_time", cur_time, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_order_err", order_err, 0);
    model_reset();
    @(posedge CPU_clk);
    @(negedge CPU_clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", req_ready, 1);
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic cycle(input logic v, input logic [63:0] t, input parsed_op_t op,
                       input logic [31:0] a, input logic te, input logic qf,
                       input logic qe);
    bit e_due, e_strobe, e_ready, was_empty;
    logic [33:0] exp_item;
    req_valid = v; req_time = t; req_opcode = op; req_address = a;
    trace_end = te; queue_full = qf; queue_empty = qe;
    #1;
    e_due    = (held.size() != 0) && (held[0].t <= m_time);
    e_strobe = e_due && !qf;
    e_ready  = !done && ((held.size() == 0) || e_strobe);
    check("op_ready_s", op_ready_s, e_strobe);
    check("req_ready", req_ready, e_ready);
    check("cur_time", cur_time, m_time);
    check("stall_cnt", stall_cnt, m_stall);
    check("order_err", order_err, m_err);
    check("all_done", all_done, done && qe);
    if (held.size() != 0) begin
      check("opcode_out", opcode_out, held[0].op);
      check("address_out", address_out, held[0].a);
    end else begin
      check("opcode_idle", opcode_out, 0);
      check("address_idle", address_out, 0);
    end
    if (op_ready_s) begin
      dut_strobes++;
      if (exp_q.size() != 0) begin
        exp_item = exp_q.pop_front();
        check("issue_order", {opcode_out, address_out}, exp_item);
      end else begin
        check("issue_unexpected", 1, 0);
      end
    end
    was_empty = (held.size() == 0);
    if (e_due && qf && m_stall != 16'hffff) m_stall++;
    if (!done) begin
      if (held.size() != 0 && qe && held[0].t > m_time && (held[0].t - m_time) > 1)
        m_time = held[0].t;
      else if (m_time != 64'hffff_ffff_ffff_ffff)
        m_time++;
    end
    if (e_strobe) void'(held.pop_front());
    if (v && e_ready) begin
      if (t < m_prev) m_err = 1;
      m_prev = t;
      held.push_back('{t: t, op: op, a: a});
      exp_q.push_back({op, a});
    end
    if (was_empty && !done && !v && te) done = 1;
    @(posedge CPU_clk);
    #1;
  endtask

  task automatic idle(input int n, input logic qf, input logic qe);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, OP_NONE, '0, 1'b0, qf, qe);
  endtask

  initial begin
    int s0;
    logic [63:0] rt;
    model_reset();
    @(posedge CPU_clk);
    #1;
    do_reset();

    // Skip-ahead: request at time 10 accepted at cur_time 2 on an empty queue.
    idle(2, 1'b0, 1'b1);
    check("skip_start_time", cur_time, 2);
    cycle(1'b1, 64'd10, OP_READ, 32'h0000_1000, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, OP_NONE, '0, 1'b0, 1'b0, 1'b1);
    check("skip_time", cur_time, 10);
    check("skip_strobe", op_ready_s, 1);
    check("skip_addr", address_out, 32'h0000_1000);
    idle(2, 1'b0, 1'b1);

    // Back-to-back: times 5,5,6 offered continuously from cur_time 5.
    @(posedge CPU_clk); #1;
    do_reset();
    idle(5, 1'b0, 1'b0);
    s0 = dut_strobes;
    cycle(1'b1, 64'd5, OP_WRITE, 32'hA0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'd5, OP_READ,  32'hA1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'd6, OP_FETCH, 32'hA2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, OP_NONE, '0, 1'b0, 1'b0, 1'b0);
    check("b2b_strobes", dut_strobes - s0, 3);
    idle(2, 1'b0, 1'b0);

    // Full queue for 7 cycles on a due request.
    cycle(1'b1, 64'd0, OP_WRITE, 32'hB0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 64'd50, OP_READ, 32'hB1, 1'b0, 1'b1, 1'b0);
    check("stall7", stall_cnt, 7);
    cycle(1'b0, '0, OP_NONE, '0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);

    // Out-of-order timestamps: 20 then 15.
    @(posedge CPU_clk); #1;
    do_reset();
    cycle(1'b1, 64'd20, OP_READ, 32'hC0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) cycle(1'b1, 64'd15, OP_WRITE, 32'hC1, 1'b0, 1'b0, 1'b0);
    check("order_err_set", order_err, 1);
    idle(3, 1'b0, 1'b0);

    // Trace end with a request still held, then drain.
    @(posedge CPU_clk); #1;
    do_reset();
    cycle(1'b1, 64'd4, OP_FETCH, 32'hD0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, OP_NONE, '0, 1'b1, 1'b0, 1'b0);
    rt = cur_time;
    idle(3, 1'b0, 1'b0);
    check("done_time_frozen", cur_time, rt);
    cycle(1'b0, '0, OP_NONE, '0, 1'b1, 1'b0, 1'b1);
    check("all_done_drained", all_done, 1);

    // Reset while a due request is blocked.
    @(posedge CPU_clk); #1;
    do_reset();
    cycle(1'b1, 64'd0, OP_READ, 32'hE0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, OP_NONE, '0, 1'b0, 1'b1, 1'b0);
    check("pre_rst_stall", stall_cnt, 3);
    s0 = dut_strobes;
    do_reset();
    check("rst_no_strobe", dut_strobes - s0, 0);
    idle(2, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ((done && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0) do_reset();
      rt = m_time + 64'($urandom_range(0, 8));
      if (m_time >= 3 && $urandom_range(0, 3) == 0) rt = m_time - 64'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, rt, parsed_op_t'($urandom_range(0, 3)),
            $urandom, $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
